// File: rtl/jk_cmd_seq_if.sv
// Command handshake between issuing control logic and the JK command sequencer.
interface jk_cmd_seq_if #(
  parameter int CNT_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_cnt,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_cnt,
    output cmd_ready
  );
endinterface

// File: rtl/jk_cmd_seq.sv
// JK command sequencer: FIFO-buffered j/k/ff_rst driver with a shadow flip-flop that flags q divergence.
// Optional JKSEQ_ABORT_EN adds an abort input that flushes the FIFO and returns to IDLE.
module jk_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  jk_cmd_seq_if.slave cmd,
  output logic        j,
  output logic        k,
  output logic        ff_rst,
  input  logic        q_in,
  output logic        expect_q,
  output logic        busy,
  output logic        mismatch,
  input  logic        mismatch_clr
`ifdef JKSEQ_ABORT_EN
  ,
  input  logic        abort
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       mem_op  [DEPTH];
  logic [CNT_W-1:0] mem_cnt [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             abort_now;
  logic [1:0]       act_op;
  logic [1:0]       act_op_nxt;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] remaining_nxt;
  logic             ff_rst_prev;
  logic             expect_q_nxt;

`ifdef JKSEQ_ABORT_EN
  assign abort_now = abort;
`else
  assign abort_now = 1'b0;
`endif

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign cmd.cmd_ready = !full && !ff_rst;
  assign push          = cmd.cmd_valid && cmd.cmd_ready && !abort_now;
  assign busy          = (state == ISSUE) || !empty;
  assign {j, k}        = (state == ISSUE) ? act_op : 2'b00;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr[AW-1:0]]  <= cmd.cmd_op;
      mem_cnt[wr_ptr[AW-1:0]] <= cmd.cmd_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (abort_now) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Back-to-back commands reload straight from the FIFO head so j/k never bubble.
  always_comb begin
    state_nxt     = state;
    act_op_nxt    = act_op;
    remaining_nxt = remaining;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop           = 1'b1;
          act_op_nxt    = mem_op[rd_ptr[AW-1:0]];
          remaining_nxt = mem_cnt[rd_ptr[AW-1:0]];
          state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        if (remaining != '0) begin
          remaining_nxt = remaining - CNT_W'(1);
        end else if (!empty) begin
          pop           = 1'b1;
          act_op_nxt    = mem_op[rd_ptr[AW-1:0]];
          remaining_nxt = mem_cnt[rd_ptr[AW-1:0]];
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_now) begin
      state_nxt     = IDLE;
      remaining_nxt = '0;
      pop           = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      act_op    <= 2'b00;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      act_op    <= act_op_nxt;
      remaining <= remaining_nxt;
    end
  end

  always_comb begin
    expect_q_nxt = expect_q;
    case ({j, k})
      2'b01:   expect_q_nxt = 1'b0;
      2'b10:   expect_q_nxt = 1'b1;
      2'b11:   expect_q_nxt = ~expect_q;
      default: expect_q_nxt = expect_q;
    endcase
  end

  // q is only trusted once ff_rst has been low for a full cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_rst      <= 1'b1;
      ff_rst_prev <= 1'b1;
      expect_q    <= 1'b0;
      mismatch    <= 1'b0;
    end else begin
      ff_rst      <= 1'b0;
      ff_rst_prev <= ff_rst;
      expect_q    <= ff_rst ? 1'b0 : expect_q_nxt;
      if (!ff_rst && !ff_rst_prev && (q_in != expect_q)) begin
        mismatch <= 1'b1;
      end else if (mismatch_clr) begin
        mismatch <= 1'b0;
      end
    end
  end

endmodule
